// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // Kept as a plain vector so any fetched word maps onto it without a cast check.
  typedef logic [6:0] opcode_t;

  localparam opcode_t OPC_LOAD   = 7'b0000011;
  localparam opcode_t OPC_IMM    = 7'b0010011;
  localparam opcode_t OPC_AUIPC  = 7'b0010111;
  localparam opcode_t OPC_STORE  = 7'b0100011;
  localparam opcode_t OPC_OP     = 7'b0110011;
  localparam opcode_t OPC_LUI    = 7'b0110111;
  localparam opcode_t OPC_BRANCH = 7'b1100011;
  localparam opcode_t OPC_JALR   = 7'b1100111;
  localparam opcode_t OPC_JAL    = 7'b1101111;
  localparam opcode_t OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/fetch_unit_fifo.sv
// rtl/fetch_unit_fifo.sv - instr_fifo: synchronous {pc, instr} response buffer, clear beats push
module instr_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == FULL_COUNT);
  assign head_data = mem[rd_ptr];
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF stage: PC, credit-limited imem requests, response FIFO, F/D register
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        d_stall,
  input  logic        e_pc_src,
  input  logic [31:0] e_pc_target,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc,
  output logic [31:0] d_pc_plus4,
  output logic        d_valid,
  output opcode_t     op,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] MAX_INFLIGHT = FIFO_DEPTH[CW:0];

  logic [XLEN-1:0]   fpc;
  logic [XLEN-1:0]   resp_pc;
  logic [XLEN-1:0]   target_aligned;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     drop_count;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       in_flight;
  logic [2*XLEN-1:0] fifo_head;
  logic              fifo_empty;
  logic              fifo_full;
  logic              issue;
  logic              accept;
  logic              bypass;
  logic              fifo_push;
  logic              fifo_pop;

  assign target_aligned = e_pc_target & ~32'd3;

  // Every issued request owns a FIFO slot, so responses can always be absorbed under stall.
  assign in_flight = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req  = !reset && !e_pc_src && !fifo_full && (in_flight < MAX_INFLIGHT);
  assign imem_addr = fpc;
  assign issue     = imem_req && imem_gnt;

  assign accept    = imem_rvalid && (drop_count == '0) && !e_pc_src;
  assign bypass    = accept && fifo_empty && !d_stall;
  assign fifo_push = accept && !bypass;
  assign fifo_pop  = !d_stall && !fifo_empty && !e_pc_src;

  instr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2*XLEN)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (e_pc_src),
    .push      (fifo_push),
    .push_data ({resp_pc, imem_rdata}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc         <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_count  <= '0;
    end else begin
      outstanding <= outstanding + CW'(issue) - CW'(imem_rvalid);
      if (e_pc_src) begin
        fpc        <= target_aligned;
        resp_pc    <= target_aligned;
        // A response landing in the redirect cycle is already wrong-path, so it is not counted.
        drop_count <= outstanding - CW'(imem_rvalid);
      end else begin
        if (issue) fpc <= fpc + 32'd4;
        if (imem_rvalid && (drop_count != '0)) drop_count <= drop_count - CW'(1);
        if (accept) resp_pc <= resp_pc + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d_instr <= NOP_INSTR;
      d_pc    <= RESET_PC;
      d_valid <= 1'b0;
    end else if (e_pc_src) begin
      d_instr <= NOP_INSTR;
      d_valid <= 1'b0;
    end else if (!d_stall) begin
      if (!fifo_empty) begin
        {d_pc, d_instr} <= fifo_head;
        d_valid         <= 1'b1;
      end else if (bypass) begin
        d_pc    <= resp_pc;
        d_instr <= imem_rdata;
        d_valid <= 1'b1;
      end else begin
        d_instr <= NOP_INSTR;
        d_valid <= 1'b0;
      end
    end
  end

  assign d_pc_plus4 = d_pc + 32'd4;
  assign op         = d_instr[6:0];
  assign funct3     = d_instr[14:12];
  assign funct7     = d_instr[31:25];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with a latency-programmable imem model
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        d_stall;
  logic        e_pc_src;
  logic [31:0] e_pc_target;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic [31:0] d_pc_plus4;
  logic        d_valid;
  opcode_t     op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .d_stall     (d_stall),
    .e_pc_src    (e_pc_src),
    .e_pc_target (e_pc_target),
    .d_instr     (d_instr),
    .d_pc        (d_pc),
    .d_pc_plus4  (d_pc_plus4),
    .d_valid     (d_valid),
    .op          (op),
    .funct3      (funct3),
    .funct7      (funct7)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic gnt; logic stall; logic req; logic [31:0] addr; logic valid; logic [31:0] pc; } vec_t;

  mreq_t       mq[$];
  logic [31:0] exp_q[$];
  vec_t        tbl[24];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          lat = 1;
  logic        gnt_en = 1'b1;
  logic [31:0] exp_fpc = RST_PC;
  logic [31:0] held_pc = '0;
  logic [31:0] held_instr = '0;
  logic        fd_new = 1'b0;
  logic        prev_redirect = 1'b0;
  logic        fresh = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  // Drive memory for this cycle, then check F/D against the scoreboard and record handshakes.
  task automatic sample();
    logic [31:0] e;
    imem_gnt = gnt_en;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mq[0].addr;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
    #1;
    fresh = 1'b0;
    if (reset) begin
      mq.delete();
      exp_q.delete();
      exp_fpc       = RST_PC;
      fd_new        = 1'b0;
      prev_redirect = 1'b0;
    end else begin
      chk("plus4", d_pc_plus4, d_pc + 32'd4);
      chk("fields", {15'd0, op, funct3, funct7}, {15'd0, d_instr[6:0], d_instr[14:12], d_instr[31:25]});
      if (prev_redirect) chk("flush_valid", {31'd0, d_valid}, 32'd0);
      if (!d_valid) begin
        chk("bubble_instr", d_instr, NOP_INSTR);
      end else if (fd_new) begin
        fresh = 1'b1;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected: got pc %h required none (cycle %0d)", d_pc, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc", d_pc, e);
          chk("sb_instr", d_instr, e);
        end
      end else begin
        chk("hold_pc", d_pc, held_pc);
        chk("hold_instr", d_instr, held_instr);
      end
      held_pc    = d_pc;
      held_instr = d_instr;
      if (e_pc_src) chk("req_in_redirect", {31'd0, imem_req}, 32'd0);
      if (imem_req && imem_gnt) begin
        chk("fetch_addr", imem_addr, exp_fpc);
        exp_q.push_back(exp_fpc);
        mq.push_back('{imem_addr, cyc + lat});
        exp_fpc = exp_fpc + 32'd4;
      end
      if (imem_rvalid) void'(mq.pop_front());
      if (e_pc_src) begin
        exp_q.delete();
        exp_fpc = e_pc_target & ~32'd3;
      end
      fd_new        = !d_stall || e_pc_src;
      prev_redirect = e_pc_src;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_valid(input string name, input logic [31:0] pc);
    logic seen = 1'b0;
    for (int n = 0; n < 30 && !seen; n++) begin
      sample();
      if (fresh) begin
        chk(name, d_pc, pc);
        seen = 1'b1;
      end
      advance();
    end
    if (!seen) timeout(name);
  endtask

  task automatic reset_state(input string name);
    chk({name, "_valid"}, {31'd0, d_valid}, 32'd0);
    chk({name, "_instr"}, d_instr, NOP_INSTR);
    chk({name, "_pc"}, d_pc, RST_PC);
    chk({name, "_req"}, {31'd0, imem_req}, 32'd0);
  endtask

  initial begin
    logic done;
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 32'h104, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 32'h108, 1'b1, 32'h100};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 32'h10C, 1'b1, 32'h104};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 32'h110, 1'b1, 32'h108};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 32'h114, 1'b1, 32'h10C};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 32'h118, 1'b1, 32'h110};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 32'h118, 1'b1, 32'h114};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 32'h118, 1'b0, 32'h0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 32'h118, 1'b0, 32'h0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 32'h118, 1'b0, 32'h0};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 32'h118, 1'b0, 32'h0};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 32'h11C, 1'b0, 32'h0};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 32'h120, 1'b1, 32'h118};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 32'h124, 1'b1, 32'h11C};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 32'h128, 1'b1, 32'h120};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 32'h12C, 1'b1, 32'h120};
    tbl[17] = '{1'b1, 1'b1, 1'b0, 32'h12C, 1'b1, 32'h120};
    tbl[18] = '{1'b1, 1'b1, 1'b0, 32'h12C, 1'b1, 32'h120};
    tbl[19] = '{1'b1, 1'b0, 1'b0, 32'h12C, 1'b1, 32'h120};
    tbl[20] = '{1'b1, 1'b0, 1'b1, 32'h12C, 1'b1, 32'h124};
    tbl[21] = '{1'b1, 1'b0, 1'b1, 32'h130, 1'b1, 32'h128};
    tbl[22] = '{1'b1, 1'b0, 1'b1, 32'h134, 1'b1, 32'h12C};
    tbl[23] = '{1'b1, 1'b0, 1'b1, 32'h138, 1'b1, 32'h130};

    reset       = 1'b1;
    d_stall     = 1'b0;
    e_pc_src    = 1'b0;
    e_pc_target = 32'h0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sample();
      advance();
    end
    reset_state("reset");

    // Zero-wait streaming, grant hold, and stall with credit back-pressure.
    reset = 1'b0;
    for (int i = 0; i < 24; i++) begin
      gnt_en  = tbl[i].gnt;
      d_stall = tbl[i].stall;
      sample();
      chk("tbl_req", {31'd0, imem_req}, {31'd0, tbl[i].req});
      if (tbl[i].req) chk("tbl_addr", imem_addr, tbl[i].addr);
      chk("tbl_valid", {31'd0, d_valid}, {31'd0, tbl[i].valid});
      if (tbl[i].valid) chk("tbl_pc", d_pc, tbl[i].pc);
      advance();
    end
    gnt_en  = 1'b1;
    d_stall = 1'b0;

    // Redirect with two slow requests still outstanding.
    lat  = 3;
    done = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      if (mq.size() == 2) done = 1'b1;
      else begin sample(); advance(); end
    end
    if (!done) timeout("two_outstanding");
    e_pc_src    = 1'b1;
    e_pc_target = 32'h203;
    sample();
    advance();
    e_pc_src = 1'b0;
    lat      = 1;
    sample();
    chk("redirect_addr", imem_addr, 32'h200);
    chk("redirect_flush", {31'd0, d_valid}, 32'd0);
    advance();
    wait_valid("redirect_first_pc", 32'h200);

    // Redirect while stalled in the same cycle a response arrives.
    lat     = 2;
    for (int i = 0; i < 4; i++) begin sample(); advance(); end
    d_stall = 1'b1;
    done    = 1'b0;
    for (int n = 0; n < 10 && !done; n++) begin
      if (mq.size() > 0 && mq[0].due <= cyc) done = 1'b1;
      else begin sample(); advance(); end
    end
    if (!done) timeout("rvalid_wait");
    e_pc_src    = 1'b1;
    e_pc_target = 32'h400;
    sample();
    chk("stall_redirect_rvalid", {31'd0, imem_rvalid}, 32'd1);
    advance();
    e_pc_src = 1'b0;
    sample();
    chk("stall_redirect_flush", {31'd0, d_valid}, 32'd0);
    advance();
    d_stall = 1'b0;
    wait_valid("stall_redirect_pc", 32'h400);

    // PC wrap at the top of the address space.
    lat         = 1;
    e_pc_src    = 1'b1;
    e_pc_target = 32'hFFFF_FFF8;
    sample();
    advance();
    e_pc_src = 1'b0;
    wait_valid("wrap_first", 32'hFFFF_FFF8);
    sample();
    chk("wrap_pc", d_pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", d_pc_plus4, 32'h0);
    advance();
    sample();
    chk("wrap_zero", d_pc, 32'h0);
    advance();

    // Reset mid-stream abandons everything in flight.
    lat = 2;
    for (int i = 0; i < 3; i++) begin sample(); advance(); end
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin sample(); advance(); end
    reset_state("midreset");
    reset = 1'b0;
    sample();
    chk("midreset_first_req", {31'd0, imem_req}, 32'd1);
    chk("midreset_first_addr", imem_addr, RST_PC);
    advance();
    wait_valid("midreset_first_pc", RST_PC);
    for (int i = 0; i < 6; i++) begin sample(); advance(); end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
